tri_pixel_collector: RTL

- Downstream of the triangle rasteriser. Consumes its pixel stream (po/xo/yo, qualified by busy) and accumulates one triangle into an 8x8 bit-mapped frame.
- After the triangle completes, streams the frame out row by row over a valid/ready handshake.
- Also reports the count of distinct lit pixels and flags stray pixels that arrive while the frame is draining.

---
 rtl/tri_pixel_collector.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tri_pixel_collector.sv
// rtl/tri_pixel_collector.sv - collects one rasterised triangle into an 8x8 bitmap and drains it row by row
module tri_pixel_collector #(
    parameter int SKIP_EMPTY = 0,
    parameter int FLIP_Y     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       busy_in,
    input  logic       po,
    input  logic [2:0] xo,
    input  logic [2:0] yo,
    output logic       row_valid,
    input  logic       row_ready,
    output logic [7:0] row_data,
    output logic [2:0] row_idx,
    output logic [6:0] pix_cnt,
    output logic       frame_done,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [2:0] FIRST_ROW = (FLIP_Y != 0) ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_ROW  = (FLIP_Y != 0) ? 3'd0 : 3'd7;

    state_t state;
    state_t state_next;

    // bitmap[y][x]: one byte per row so a whole row can be presented at once
    logic [7:0][7:0] bitmap;
    logic            busy_d;

    logic       fall;
    logic       capture_en;
    logic       new_bit;
    logic       drain_start;
    logic       xfer;
    logic       advance;
    logic       search_blocked;
    logic [2:0] search_base;
    logic [7:0] cand;
    logic       found;
    logic [2:0] sel;

    assign fall        = busy_d & ~busy_in;
    assign capture_en  = po && ((state == IDLE) || (state == CAPTURE));
    assign new_bit     = capture_en && !bitmap[yo][xo];

    // In DRAIN, row_valid low means no row has been chosen yet (the first cycle after entry)
    assign drain_start = (state == DRAIN) && !row_valid;
    assign xfer        = row_valid && row_ready;
    assign advance     = drain_start || xfer;

    // Once the last row in drain order has been accepted there is nothing left to choose
    assign search_blocked = xfer && (row_idx == LAST_ROW);
    assign search_base    = drain_start ? FIRST_ROW :
                            ((FLIP_Y != 0) ? (row_idx - 3'd1) : (row_idx + 3'd1));

    // Rows still ahead of the pointer in drain order, minus empty ones when skipping
    always_comb begin
        cand = 8'h00;
        for (int y = 0; y < 8; y++) begin
            cand[y] = !search_blocked
                   && ((FLIP_Y != 0) ? (3'(y) <= search_base) : (3'(y) >= search_base))
                   && ((SKIP_EMPTY == 0) || (bitmap[y] != 8'h00));
        end
    end

    assign found = |cand;

    // Nearest candidate in drain direction: lowest y going up, highest y going down
    always_comb begin
        sel = search_base;
        if (FLIP_Y != 0) begin
            for (int y = 0; y < 8; y++) begin
                if (cand[y]) sel = 3'(y);
            end
        end else begin
            for (int y = 7; y >= 0; y--) begin
                if (cand[y]) sel = 3'(y);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (po || busy_in) state_next = CAPTURE;
            CAPTURE: if (fall) state_next = DRAIN;
            DRAIN:   if (advance && !found) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture, pixel counting, row presentation and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitmap     <= '0;
            busy_d     <= 1'b0;
            pix_cnt    <= 7'd0;
            row_valid  <= 1'b0;
            row_idx    <= 3'd0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            busy_d     <= busy_in;
            frame_done <= 1'b0;

            if (po && (state == DRAIN)) ovf <= 1'b1;

            if (capture_en) bitmap[yo][xo] <= 1'b1;

            // The count of the finished frame is kept until the next frame begins
            if ((state == IDLE) && (po || busy_in))
                pix_cnt <= {6'd0, po};
            else if ((state == CAPTURE) && new_bit)
                pix_cnt <= pix_cnt + 7'd1;

            if ((state == DRAIN) && advance) begin
                if (found) begin
                    row_valid <= 1'b1;
                    row_idx   <= sel;
                end else begin
                    row_valid  <= 1'b0;
                    frame_done <= 1'b1;
                    bitmap     <= '0;
                end
            end
        end
    end

    assign row_data = row_valid ? bitmap[row_idx] : 8'h00;

endmodule
